// File: rtl/pc_stall_watchdog.sv
// PC-progress monitor: flags a hang when the PC holds for STALL_LIMIT compares.
// Optional recent-PC trace buffer enabled by defining PCWD_TRACE_BUF_EN.
module pc_stall_watchdog #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 64,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           clear,
    input  logic [XLEN-1:0]                pc_in,
    input  logic [XLEN-1:0]                instr_in,
    output logic                           stuck,
    output logic                           stuck_pulse,
    output logic [XLEN-1:0]                stuck_pc,
    output logic [XLEN-1:0]                stuck_instr,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic [CNT_W-1:0]               max_stall,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]                trace_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
);
    localparam int IDX_W = $clog2(TRACE_DEPTH);

    typedef enum logic [1:0] {PRIME, RUN, STUCK} state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   last_pc;
    logic [CNT_W-1:0]  cnt_n;
    logic              load_pc, push, trigger;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= PRIME;
        else          state <= state_n;
    end

    // clear overrides everything, including a same-cycle trigger or PC advance
    always_comb begin
        state_n = state;
        cnt_n   = stall_cnt;
        load_pc = 1'b0;
        push    = 1'b0;
        trigger = 1'b0;
        if (clear) begin
            cnt_n   = '0;
            load_pc = 1'b1;
            if (state == STUCK) state_n = RUN;
        end else if (enable) begin
            case (state)
                PRIME: begin
                    load_pc = 1'b1;
                    push    = 1'b1;
                    cnt_n   = '0;
                    state_n = RUN;
                end
                default: begin
                    if (pc_in == last_pc) begin
                        cnt_n = (stall_cnt == '1) ? stall_cnt : stall_cnt + CNT_W'(1);
                    end else begin
                        cnt_n   = '0;
                        load_pc = 1'b1;
                        push    = 1'b1;
                    end
                end
            endcase
            if (state == RUN && cnt_n == CNT_W'(STALL_LIMIT)) begin
                trigger = 1'b1;
                state_n = STUCK;
            end
        end
    end

    assign stuck = (state == STUCK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pc     <= '0;
            stall_cnt   <= '0;
            max_stall   <= '0;
            stuck_pulse <= 1'b0;
            stuck_pc    <= '0;
            stuck_instr <= '0;
        end else begin
            if (load_pc) last_pc <= pc_in;
            stall_cnt   <= cnt_n;
            max_stall   <= (cnt_n > max_stall) ? cnt_n : max_stall;
            stuck_pulse <= trigger;
            if (trigger) begin
                stuck_pc    <= last_pc;
                stuck_instr <= instr_in;
            end
        end
    end

`ifdef PCWD_TRACE_BUF_EN
    logic [XLEN-1:0]  mem [TRACE_DEPTH];
    logic [IDX_W-1:0] wptr, rd_ptr;
    logic [IDX_W:0]   tcnt;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= pc_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            tcnt <= '0;
        end else if (push) begin
            wptr <= wptr + IDX_W'(1);
            if (tcnt != (IDX_W+1)'(TRACE_DEPTH)) tcnt <= tcnt + (IDX_W+1)'(1);
        end
    end

    // index 0 is the most recently written entry
    assign rd_ptr      = wptr - IDX_W'(1) - trace_idx;
    assign trace_pc    = ({1'b0, trace_idx} < tcnt) ? mem[rd_ptr] : '0;
    assign trace_count = tcnt;
`else
    logic unused_sig;
    assign unused_sig  = ^{trace_idx, push};
    assign trace_pc    = '0;
    assign trace_count = '0;
`endif

endmodule

// File: tb/tb_pc_stall_watchdog.sv
// Randomized + directed bench for pc_stall_watchdog against a queue-based reference model.
module tb_pc_stall_watchdog;
    localparam int XLEN = 32, CNT_W = 4, LIMIT = 4, DEPTH = 4, IW = 2;
    localparam int CMAX = 15;

    logic              clk = 1'b0, reset_n = 1'b0, enable = 1'b0, clear = 1'b0;
    logic [XLEN-1:0]   pc_in = '0, instr_in = '0;
    logic              stuck, stuck_pulse;
    logic [XLEN-1:0]   stuck_pc, stuck_instr, trace_pc;
    logic [CNT_W-1:0]  stall_cnt, max_stall;
    logic [IW-1:0]     trace_idx = '0;
    logic [IW:0]       trace_count;

    pc_stall_watchdog #(.XLEN(XLEN), .CNT_W(CNT_W), .STALL_LIMIT(LIMIT), .TRACE_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .pc_in(pc_in), .instr_in(instr_in),
        .stuck(stuck), .stuck_pulse(stuck_pulse), .stuck_pc(stuck_pc), .stuck_instr(stuck_instr),
        .stall_cnt(stall_cnt), .max_stall(max_stall),
        .trace_idx(trace_idx), .trace_pc(trace_pc), .trace_count(trace_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // reference model: plain bits/ints, trace kept as newest-first queue of distinct PCs
    bit              m_primed, m_stuck, m_pulse;
    int              m_cnt, m_max;
    logic [XLEN-1:0] m_last, m_spc, m_sinstr;
    logic [XLEN-1:0] hist[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_primed = 0; m_stuck = 0; m_pulse = 0;
        m_cnt = 0; m_max = 0;
        m_last = '0; m_spc = '0; m_sinstr = '0;
        hist.delete();
    endtask

    task automatic m_push(input logic [XLEN-1:0] pc);
        hist.push_front(pc);
        if (hist.size() > DEPTH) void'(hist.pop_back());
    endtask

    task automatic m_edge(input bit en, input bit clr, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] ins);
        m_pulse = 0;
        if (clr) begin
            m_cnt = 0; m_last = pc; m_stuck = 0;
        end else if (en) begin
            if (!m_primed) begin
                m_primed = 1; m_last = pc; m_cnt = 0; m_push(pc);
            end else if (pc == m_last) begin
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                if (!m_stuck && m_cnt == LIMIT) begin
                    m_stuck = 1; m_pulse = 1; m_spc = pc; m_sinstr = ins;
                end
            end else begin
                m_cnt = 0; m_last = pc; m_push(pc);
            end
        end
        if (m_cnt > m_max) m_max = m_cnt;
    endtask

    task automatic check_all();
        logic [XLEN-1:0] exp_tpc;
        chk("stuck", stuck, m_stuck);
        chk("stuck_pulse", stuck_pulse, m_pulse);
        chk("stall_cnt", stall_cnt, m_cnt);
        chk("max_stall", max_stall, m_max);
        chk("stuck_pc", stuck_pc, m_spc);
        chk("stuck_instr", stuck_instr, m_sinstr);
`ifdef PCWD_TRACE_BUF_EN
        exp_tpc = (int'(trace_idx) < hist.size()) ? hist[int'(trace_idx)] : '0;
        chk("trace_count", trace_count, hist.size());
`else
        exp_tpc = '0;
        chk("trace_count", trace_count, 0);
`endif
        chk("trace_pc", trace_pc, exp_tpc);
    endtask

    task automatic step(input bit en, input bit clr, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] ins);
        enable = en; clear = clr; pc_in = pc; instr_in = ins;
        trace_idx = IW'($urandom_range(0, DEPTH-1));
        @(posedge clk);
        m_edge(en, clr, pc, ins);
        #1 check_all();
    endtask

    // asynchronous reset mid-cycle; outputs must drop before any clock edge
    task automatic do_reset();
        #2 reset_n = 1'b0;
        enable = 1'b0; clear = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("rst_stuck", stuck, 0);
        chk("rst_stuck_pc", stuck_pc, 0);
        chk("rst_max", max_stall, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [XLEN-1:0] cur;
        m_reset();
        #1 check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // 1: advancing PC never stalls
        for (int i = 0; i < 20; i++) step(1, 0, XLEN'(i*4), $urandom);
        chk("t1_max", max_stall, 0);

        // 2: 0x50 advance then 6 same-PC compares
        for (int i = 0; i < 7; i++) step(1, 0, 32'h50, $urandom);
        chk("t2_pc", stuck_pc, 32'h50);
        chk("t2_max", max_stall, 6);

        // 3: saturation
        for (int i = 0; i < 20; i++) step(1, 0, 32'h50, $urandom);
        chk("t3_sat", stall_cnt, CMAX);

        // 4: clear with simultaneous advance, then re-trigger
        step(1, 1, 32'h54, $urandom);
        chk("t4_clr", stuck, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 32'h54, $urandom);
        chk("t4_re", stuck, 1);
        chk("t4_pc", stuck_pc, 32'h54);

        // 5: enable low freezes, then reset mid-STUCK
        for (int i = 0; i < 10; i++) step(0, 0, 32'h54, $urandom);
        do_reset();

        // 6: trace contents
        for (int i = 0; i < 5; i++) step(1, 0, XLEN'(32'h10 + i*4), $urandom);
        for (int i = 0; i < DEPTH; i++) begin
            trace_idx = IW'(i);
            #1 check_all();
        end
`ifdef PCWD_TRACE_BUF_EN
        trace_idx = 0; #1 chk("t6_idx0", trace_pc, 32'h20);
        trace_idx = 3; #1 chk("t6_idx3", trace_pc, 32'h14);
        chk("t6_cnt", trace_count, 4);
`else
        chk("t6_cnt", trace_count, 0);
`endif

        // random phase
        cur = 32'h100;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 9) < 3) cur = XLEN'($urandom_range(0, 7) * 4);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, cur, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
